// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps a 3-input block through all vectors and checks its truth table
//
// Optional feature macro: TT_SEQ_STOP_ON_FAIL_EN (end the run at the first mismatching vector).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             run request, honoured only while idle
//   expected[7:0]     expected table, bit i = Y for vector i = {A,B,C}; latched on start
//   dut_a/b/c         registered drive to the block under test, {A,B,C} = vector index
//   dut_y             output of the block under test
//   busy              high from the accepting edge until DONE is left
//   done              one-cycle end-of-run pulse
//   table_out[7:0]    captured truth table
//   pass              table matched expected; valid from done
//   err_count[3:0]    number of mismatching vectors
//   fail_idx[2:0]     first mismatching vector, 0 if none
module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  // The counter runs reload..0, so SETTLE occupies exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] exp_q;
  logic       mismatch;
  logic [3:0] err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mismatch   = (dut_y != exp_q[idx]);
    err_next   = err_count + {3'b000, mismatch};
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: if (cnt == 4'd0) state_next = SAMPLE;
      SAMPLE: begin
`ifdef TT_SEQ_STOP_ON_FAIL_EN
        if (mismatch || idx == 3'd7) state_next = DONE;
        else                         state_next = SETTLE;
`else
        if (idx == 3'd7) state_next = DONE;
        else             state_next = SETTLE;
`endif
      end
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= 3'd0;
      cnt       <= 4'd0;
      exp_q     <= 8'h00;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      dut_c     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= 8'h00;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_idx  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q     <= expected;
            table_out <= 8'h00;
            err_count <= 4'd0;
            fail_idx  <= 3'd0;
            pass      <= 1'b0;
            idx       <= 3'd0;
            {dut_a, dut_b, dut_c} <= 3'b000;
            cnt       <= CNT_RELOAD;
            busy      <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          table_out[idx] <= dut_y;
          if (mismatch) begin
            err_count <= err_next;
            // err_count still zero means this is the first mismatch of the run.
            if (err_count == 4'd0) fail_idx <= idx;
          end
          if (state_next == SETTLE) begin
            idx <= idx + 3'd1;
            {dut_a, dut_b, dut_c} <= idx + 3'd1;
            cnt <= CNT_RELOAD;
          end else begin
            // pass is resolved here, using the post-sample count, so it is valid with done.
            done <= 1'b1;
            pass <= (err_next == 4'd0);
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - scoreboard bench for truth_table_sequencer against a majority gate
module tb_truth_table_sequencer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       dut_a, dut_b, dut_c, dut_y;
  logic       busy, done, pass;
  logic [7:0] table_out;
  logic [3:0] err_count;
  logic [2:0] fail_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] tbl;
    logic [3:0] err;
    logic [2:0] fidx;
    logic       pass;
    int         done_edge;
  } exp_t;

  exp_t sb[$];

  truth_table_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_y(dut_y),
    .busy(busy), .done(done), .table_out(table_out), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx)
  );

  // Block under test: 3-input majority.
  assign dut_y = (dut_a & dut_b) | (dut_a & dut_c) | (dut_b & dut_c);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [7:0] e);
    exp_t r;
    logic [7:0] maj, x;
    int k;
    maj = 8'h00;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      maj[i] = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    end
    x = maj ^ e;
    k = 0;
    for (int i = 7; i >= 0; i--) if (x[i]) k = i;
    r.tbl = maj; r.err = 4'd0; r.fidx = 3'd0; r.pass = 1'b1; r.done_edge = 8 * (S + 1);
    if (x != 8'h00) begin
      r.pass = 1'b0;
      r.fidx = 3'(k);
`ifdef TT_SEQ_STOP_ON_FAIL_EN
      r.err = 4'd1;
      r.tbl = maj & ((8'h01 << k) - 8'h01);
      r.done_edge = (k + 1) * (S + 1);
`else
      r.err = 4'd0;
      for (int i = 0; i < 8; i++) r.err = r.err + 4'(x[i]);
`endif
    end
    return r;
  endfunction

  function automatic logic [31:0] all_outs();
    return {17'd0, busy, done, table_out, pass, err_count, fail_idx, dut_a, dut_b, dut_c};
  endfunction

  // Runs one sweep from the current idle negedge. With glitch set, start is re-pulsed and
  // expected is changed mid-run; the scoreboard entry pushed at acceptance must still hold.
  task automatic run(input string tag, input logic [7:0] e, input bit glitch);
    exp_t m;
    int cyc;
    bit seen;
    start = 1'b1;
    expected = e;
    sb.push_back(model(e));
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      if (done) begin
        m = sb.pop_front();
        check({tag, "_done_edge"}, 32'(cyc), 32'(m.done_edge));
        check({tag, "_table"}, 32'(table_out), 32'(m.tbl));
        check({tag, "_err"}, 32'(err_count), 32'(m.err));
        check({tag, "_fidx"}, 32'(fail_idx), 32'(m.fidx));
        check({tag, "_pass"}, 32'(pass), 32'(m.pass));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        seen = 1'b1;
      end else begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_vec"}, 32'({dut_a, dut_b, dut_c}),
              32'((cyc / (S + 1)) > 7 ? 7 : cyc / (S + 1)));
        if (glitch && cyc == 4) begin
          start = 1'b1;
          expected = 8'h00;
        end else if (glitch && cyc == 5) begin
          start = 1'b0;
        end
      end
      cyc++;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'(cyc), 32'd0);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    // Asynchronous reset applied mid-cycle.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_vec", 32'({dut_a, dut_b, dut_c}), 32'd0);

    run("maj_e8", 8'hE8, 1'b0);
    run("maj_e9", 8'hE9, 1'b0);
    run("maj_17", 8'h17, 1'b0);
    run("glitch", 8'hE8, 1'b1);

    // Abort while vector 4 is being driven; the partial run is discarded.
    start = 1'b1;
    expected = 8'hE8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("abort_vec4", 32'({dut_a, dut_b, dut_c}), 32'd4);
    #2 rst = 1'b1;
    #1 check("abort_outs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dut", 32'({dut_a, dut_b, dut_c}), 32'd0);

    run("after_abort", 8'hE8, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer that exercises a 3-input combinational block (inputs A, B, C; output Y) on hardware. On `start` it drives all eight input vectors in ascending order, waits a programmable settle time per vector, and captures Y into an 8-bit truth-table register. It compares that register against an expected table and reports pass/fail, error count and first failing vector. It sits between a control source (switches, host or bench) and the combinational block under test.

## Interface
- `SETTLE_CYCLES`, 2: cycles each vector is held before Y is sampled; legal range 1–15.
- `clk`  in  1  clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `expected`  in  8  expected truth table; bit i = Y for vector i = {A,B,C}; captured when `start` is accepted.
- `dut_a`, `dut_b`, `dut_c`  out  1 each  registered drive to the block under test; {A,B,C} = current vector index.
- `dut_y`  in  1  output of the block under test.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE is left.
- `done`  out  1  one-cycle pulse at end of run.
- `table_out`  out  8  captured truth table.
- `pass`  out  1  `table_out == expected` for the last run; valid from `done`.
- `err_count`  out  4  number of mismatching vectors, 0–8.
- `fail_idx`  out  3  index of the first mismatching vector; 0 if none.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with `start`=1:
  - Capture `expected`.
  - Clear `table_out`, `err_count`, `fail_idx` and `pass`.
  - Set idx=0 and drive `dut_*`=000.
  - Load the settle counter and go to SETTLE.
- SETTLE lasts exactly `SETTLE_CYCLES` cycles, then goes to SAMPLE.
- SAMPLE (one cycle):
  - `table_out[idx]` <= `dut_y`.
  - On mismatch with `expected[idx]`: `err_count`++; if this is the first mismatch, `fail_idx` <= idx.
  - If idx==7, go to DONE. Otherwise idx++, update `dut_*`, reload the counter and go to SETTLE.
- DONE (one cycle): `done`=1, `pass` <= (`err_count`==0 after the last sample), then return to IDLE.
- `table_out`, `err_count`, `fail_idx` and `pass` hold their values until the next accepted `start`.
- `start` while `busy` is ignored; it is neither queued nor a restart.
- Changes on `expected` after acceptance have no effect on the current run.
- The idx counter does not wrap; the run ends at idx 7.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0.
- `rst` mid-run aborts immediately to the reset state. Partial results are discarded. The next `start` runs a full sweep.
- Let E0 be the edge on which `start` is accepted (idle-to-SETTLE transition).
- Vector k is driven from E0+k·(S+1) and captured at edge E0+k·(S+1)+S+1, where S=`SETTLE_CYCLES`.
- `done` is high in the cycle following edge E0+8·(S+1). With S=2 this is 24 edges after E0.
- `busy` rises at E0 and falls in the same edge that ends the `done` pulse.
- A new `start` is accepted no earlier than the first IDLE cycle after `done`.
- All outputs are registered; there is no combinational path from `dut_y` to any output.

## Configuration
- `TT_SEQ_STOP_ON_FAIL_EN` defined:
  - SAMPLE with a mismatch goes straight to DONE, with `err_count`=1 and `fail_idx`=idx.
  - Unsampled `table_out` bits stay 0.
  - `done` follows the failing sample by one edge.
- Not defined: every run performs the full 8-vector sweep and `err_count` counts all mismatches.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; after release, `busy`=0 and `dut_*`=000.
- Majority model (Y=AB+AC+BC), `expected`=8'hE8, S=2, pulse `start` -> `dut_*` steps 000..111 every 3 cycles; `done` 24 edges after E0; `table_out`=8'hE8, `pass`=1, `err_count`=0.
- Majority model, `expected`=8'hE9:
  - Macro undefined: `table_out`=8'hE8, `err_count`=1, `fail_idx`=0, `pass`=0.
  - Macro defined: `done` 3 edges after E0, `table_out`=8'h00, `fail_idx`=0.
- Majority model, `expected`=8'h17, macro undefined -> `err_count`=8, `fail_idx`=0, `pass`=0.
- During a run, pulse `start` again and change `expected` to 8'h00 -> no restart; results match the original `expected`=8'hE8 run.
- Assert `rst` while idx=4 -> outputs 0, state IDLE; next `start` with `expected`=8'hE8 gives a full 24-edge run and `pass`=1.
